// File: rtl/irq_servicer_if.sv
// Initiator-side peripheral port driven by irq_servicer: chip select plus
// single-cycle read/write strobes.
//
// Handshake: a transfer is one cycle with m_cs_n low and exactly one of
// m_read or m_write high. There is no ready or wait signal. Write data is
// valid in the strobe cycle. Read data is valid READ_LATENCY cycles after
// the read strobe and is sampled in that cycle only.
interface irq_servicer_if;
    logic        m_cs_n;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_readdata;
    logic [31:0] m_writedata;

    modport master (
        output m_cs_n, m_read, m_write, m_writedata,
        input  m_readdata
    );

    modport slave (
        input  m_cs_n, m_read, m_write, m_writedata,
        output m_readdata
    );
endinterface

// File: rtl/irq_servicer.sv
// Hardware interrupt servicer: reads the peripheral status and writes an
// acknowledge. It retries the write until irq drops, and halts after too many retries.
module irq_servicer #(
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] ACK_DATA     = 32'h0000_0000,
    parameter int unsigned CLR_TIMEOUT  = 8,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             irq,
    input  logic             enable,
    input  logic             err_clr,
    irq_servicer_if.master   bus,
    output logic             busy,
    output logic [15:0]      event_count,
    output logic [31:0]      last_data,
    output logic             timeout_err,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        RWAIT   = 3'd2,
        WRITE   = 3'd3,
        CLRWAIT = 3'd4,
        HALT    = 3'd5
    } state_t;

    localparam logic [7:0] RL_LAST   = 8'(READ_LATENCY - 1);
    localparam logic [7:0] CT_LAST   = 8'(CLR_TIMEOUT - 1);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

    state_t     state;
    state_t     state_nx;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nx;
    logic [2:0] retry_cnt;
    logic [2:0] retry_nx;
    logic       ev_inc;
    logic       capture;
    logic       err_set;

    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        retry_nx = retry_cnt;
        ev_inc   = 1'b0;
        capture  = 1'b0;
        err_set  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && irq) begin
                    state_nx = READ;
                    wait_nx  = 8'd0;
                end
            end
            READ: begin
                state_nx = RWAIT;
                wait_nx  = 8'd0;
            end
            RWAIT: begin
                if (wait_cnt == RL_LAST) begin
                    capture  = 1'b1;
                    state_nx = WRITE;
                    wait_nx  = 8'd0;
                end else begin
                    wait_nx = wait_cnt + 8'd1;
                end
            end
            WRITE: begin
                wait_nx  = 8'd0;
                state_nx = CLRWAIT;
            end
            CLRWAIT: begin
                // A dropped irq wins over the timeout in the same cycle.
                if (!irq) begin
                    ev_inc   = 1'b1;
                    retry_nx = 3'd0;
                    state_nx = IDLE;
                end else if (wait_cnt == CT_LAST) begin
                    if (retry_cnt < RETRY_MAX) begin
                        retry_nx = retry_cnt + 3'd1;
                        state_nx = WRITE;
                    end else begin
                        err_set  = 1'b1;
                        retry_nx = 3'd0;
                        state_nx = HALT;
                    end
                end else begin
                    wait_nx = wait_cnt + 8'd1;
                end
            end
            HALT: begin
                if (err_clr) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            wait_cnt        <= 8'd0;
            retry_cnt       <= 3'd0;
            bus.m_cs_n      <= 1'b1;
            bus.m_read      <= 1'b0;
            bus.m_write     <= 1'b0;
            bus.m_writedata <= 32'h0;
            busy            <= 1'b0;
            event_count     <= 16'd0;
            last_data       <= 32'h0;
            timeout_err     <= 1'b0;
        end else begin
            state           <= state_nx;
            wait_cnt        <= wait_nx;
            retry_cnt       <= retry_nx;
            bus.m_cs_n      <= !((state_nx == READ) || (state_nx == WRITE));
            bus.m_read      <= (state_nx == READ);
            bus.m_write     <= (state_nx == WRITE);
            bus.m_writedata <= (state_nx == WRITE) ? ACK_DATA : 32'h0;
            busy            <= !((state_nx == IDLE) || (state_nx == HALT));
            if (ev_inc) begin
                event_count <= event_count + 16'd1;
            end
            if (capture) begin
                last_data <= bus.m_readdata;
            end
            if (err_set) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_irq_servicer.sv
// Bench for irq_servicer: a default-parameter instance driven by a vector table, and a
// tuned instance driven by directed and random service transactions.
module tb_irq_servicer;

    localparam int          RL  = 3;
    localparam int          CT  = 4;
    localparam int          MR  = 2;
    localparam logic [31:0] ACK = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        irq;
    logic        enable;
    logic        err_clr;
    logic [31:0] rd;

    logic        busy_a, busy_b, err_a, err_b;
    logic [15:0] ev_a, ev_b;
    logic [31:0] last_a, last_b;
    logic [2:0]  st_a, st_b;

    int n_total = 0;
    int n_pass  = 0;

    logic [15:0] ev_exp;
    logic [31:0] last_exp;
    logic        err_exp;

    always #5 clk = ~clk;

    irq_servicer_if bus_a ();
    irq_servicer_if bus_b ();
    assign bus_a.m_readdata = rd;
    assign bus_b.m_readdata = rd;

    irq_servicer #(
        .READ_LATENCY (RL),
        .ACK_DATA     (ACK),
        .CLR_TIMEOUT  (CT),
        .MAX_RETRY    (MR)
    ) dut_a (
        .clk         (clk),
        .reset_n     (reset_n),
        .irq         (irq),
        .enable      (enable),
        .err_clr     (err_clr),
        .bus         (bus_a),
        .busy        (busy_a),
        .event_count (ev_a),
        .last_data   (last_a),
        .timeout_err (err_a),
        .state_dbg   (st_a)
    );

    irq_servicer dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .irq         (irq),
        .enable      (enable),
        .err_clr     (err_clr),
        .bus         (bus_b),
        .busy        (busy_b),
        .event_count (ev_b),
        .last_data   (last_b),
        .timeout_err (err_b),
        .state_dbg   (st_b)
    );

    typedef struct {
        logic        irq;
        logic        en;
        logic [31:0] rd;
        logic        cs_n;
        logic        rd_s;
        logic        wr_s;
        logic        busy;
        logic [15:0] ev;
        logic [31:0] last;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        irq     = 1'b0;
        enable  = 1'b0;
        err_clr = 1'b0;
        rd      = 32'h0;
        step();
        step();
        chk("rst_bus", {bus_a.m_cs_n, bus_a.m_read, bus_a.m_write, busy_a}, 4'b1000);
        chk("rst_wdata", bus_a.m_writedata, 32'h0);
        chk("rst_count", ev_a, 16'd0);
        chk("rst_last", last_a, 32'h0);
        chk("rst_err", err_a, 1'b0);
        chk("rst_b", {bus_b.m_cs_n, busy_b, ev_b, last_b, err_b}, {2'b10, 16'd0, 32'h0, 1'b0});
        reset_n  = 1'b1;
        ev_exp   = 16'd0;
        last_exp = 32'h0;
        err_exp  = 1'b0;
    endtask

    // One service transaction on dut_a. The peripheral drops irq after the k-th
    // acknowledge write. The expected bus activity for every cycle is worked out
    // from the sequence lengths. err_clr is pulsed at random while the DUT is busy.
    task automatic run_service(input int k, input logic [31:0] status, input bit toggle_en);
        int   nwr_exp, len_exp, wr_seen;
        bit   tmo;
        logic exp_rd, exp_wr, exp_busy;
        tmo     = (k > 1 + MR);
        nwr_exp = tmo ? 1 + MR : k;
        len_exp = tmo ? 1 + RL + (1 + MR) * (1 + CT) : 1 + RL + (k - 1) * (1 + CT) + 2;
        wr_seen = 0;
        enable  = 1'b1;
        irq     = 1'b1;
        rd      = $urandom;
        step();
        for (int c = 0; c <= len_exp; c++) begin
            if (c > 0) step();
            exp_rd   = (c == 0);
            exp_wr   = (c >= 1 + RL) && (((c - 1 - RL) % (1 + CT)) == 0) &&
                       (((c - 1 - RL) / (1 + CT)) < nwr_exp);
            exp_busy = (c < len_exp);
            chk("seq_bus", {bus_a.m_cs_n, bus_a.m_read, bus_a.m_write, busy_a},
                {!(exp_rd || exp_wr), exp_rd, exp_wr, exp_busy});
            if (bus_a.m_write) begin
                wr_seen++;
                chk("ack_data", bus_a.m_writedata, ACK);
                if (wr_seen == k) irq = 1'b0;
            end
            rd      = (c == RL) ? status : $urandom;
            err_clr = (c < len_exp) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (toggle_en && c == 1) enable = 1'b0;
        end
        err_clr  = 1'b0;
        last_exp = status;
        if (tmo) err_exp = 1'b1;
        else     ev_exp  = ev_exp + 16'd1;
        chk("writes", wr_seen, nwr_exp);
        chk("count", ev_a, ev_exp);
        chk("last_data", last_a, last_exp);
        chk("timeout_err", err_a, err_exp);
    endtask

    // Completes a sequence whose READ strobe is showing now, with irq already cleared.
    task automatic finish_seq(input logic [31:0] status);
        rd  = status;
        irq = 1'b0;
        for (int i = 0; i < 40 && busy_a; i++) step();
        chk("finish_idle", busy_a, 1'b0);
        ev_exp   = ev_exp + 16'd1;
        last_exp = status;
        chk("finish_count", ev_a, ev_exp);
        chk("finish_last", last_a, last_exp);
    endtask

    task automatic recover_halt();
        err_clr = 1'b1;
        irq     = 1'b0;
        step();
        err_clr = 1'b0;
        err_exp = 1'b0;
        chk("recover_err", err_a, 1'b0);
        chk("recover_busy", busy_a, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 32'hDEAD_BEEF};
        tbl[5]  = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 32'hDEAD_BEEF};
        tbl[6]  = '{1'b1, 1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 32'hDEAD_BEEF};
        tbl[7]  = '{1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 32'hDEAD_BEEF};
        tbl[8]  = '{1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 32'h1234_5678};
        tbl[9]  = '{1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 32'h1234_5678};
        tbl[10] = '{1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 32'h1234_5678};
        tbl[11] = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 32'h1234_5678};
        tbl[12] = '{1'b1, 1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 32'h1234_5678};
        tbl[13] = '{1'b1, 1'b0, 32'h3333_3333, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 32'h1234_5678};
        tbl[14] = '{1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 32'hCAFE_F00D};
        tbl[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 32'hCAFE_F00D};
        tbl[16] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 32'hCAFE_F00D};
        tbl[17] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 32'hCAFE_F00D};
        tbl[18] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 32'hCAFE_F00D};

        do_reset();

        // Default-parameter instance, cycle by cycle.
        for (int i = 0; i < 19; i++) begin
            irq    = tbl[i].irq;
            enable = tbl[i].en;
            rd     = tbl[i].rd;
            step();
            chk("tbl_bus", {bus_b.m_cs_n, bus_b.m_read, bus_b.m_write, busy_b},
                {tbl[i].cs_n, tbl[i].rd_s, tbl[i].wr_s, tbl[i].busy});
            chk("tbl_wdata", bus_b.m_writedata, 32'h0);
            chk("tbl_count", ev_b, tbl[i].ev);
            chk("tbl_last", last_b, tbl[i].last);
        end

        do_reset();
        step();

        // Clean single service, drop on the first retry, and stuck irq into HALT.
        run_service(1, 32'hDEAD_BEEF, 1'b0);
        run_service(2, 32'h0000_1234, 1'b0);
        run_service(4, 32'h0BAD_F00D, 1'b0);

        enable = 1'b1;
        irq    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt_hold", {bus_a.m_cs_n, bus_a.m_read, bus_a.m_write, busy_a, err_a}, 5'b10001);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        err_exp = 1'b0;
        chk("errclr_err", err_a, 1'b0);
        chk("errclr_idle", {busy_a, bus_a.m_read}, 2'b00);
        step();
        chk("errclr_reread", {bus_a.m_cs_n, bus_a.m_read}, 2'b01);
        finish_seq(32'h5555_AAAA);

        // Counter wrap from a preloaded all-ones value.
        step();
        force dut_a.event_count = 16'hFFFF;
        step();
        release dut_a.event_count;
        ev_exp = 16'hFFFF;
        run_service(1, 32'h7777_0001, 1'b1);

        // Disabled: irq alone must not start a sequence.
        enable = 1'b0;
        irq    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("disabled_quiet", {bus_a.m_cs_n, bus_a.m_read, bus_a.m_write, busy_a}, 4'b1000);
        end

        // Random transactions.
        for (int n = 0; n < 25; n++) begin
            int k;
            k = $urandom_range(1, 4);
            run_service(k, $urandom, 1'($urandom_range(0, 1)));
            if (k > 1 + MR) recover_halt();
            enable = 1'b0;
            irq    = 1'($urandom_range(0, 1));
            for (int g = 0; g <= int'($urandom_range(0, 3)); g++) begin
                step();
                chk("gap_quiet", {bus_a.m_cs_n, busy_a}, 2'b10);
            end
        end

        // Asynchronous reset during the acknowledge write.
        enable = 1'b1;
        irq    = 1'b1;
        for (int i = 0; i < 20 && !bus_a.m_write; i++) step();
        chk("pre_reset_write", bus_a.m_write, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_bus", {bus_a.m_cs_n, bus_a.m_read, bus_a.m_write, busy_a}, 4'b1000);
        chk("async_rst_regs", {bus_a.m_writedata, ev_a, last_a, err_a}, {32'h0, 16'd0, 32'h0, 1'b0});
        reset_n  = 1'b1;
        ev_exp   = 16'd0;
        last_exp = 32'h0;
        err_exp  = 1'b0;
        step();
        chk("post_rst_read", {bus_a.m_cs_n, bus_a.m_read, busy_a}, 3'b011);
        finish_seq(32'h0F0F_1234);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/irq_servicer.md
# irq_servicer

Hardware interrupt servicer that sits on the initiator side of a peripheral's chip-select/read/write slave port (e.g. the timer peripherals). On a level interrupt it reads the peripheral's status word, writes an acknowledge word to clear the interrupt, and confirms the interrupt dropped, retrying on timeout. It counts serviced events and latches the last status read, so simple peripherals can be used without a CPU interrupt handler.

## Interface

Parameters:
- READ_LATENCY, 1: cycles from read strobe to valid m_readdata; legal range 1..15.
- ACK_DATA, 32'h0000_0000: value driven on m_writedata during the acknowledge write.
- CLR_TIMEOUT, 8: cycles to wait for irq low after a write; legal range 1..255.
- MAX_RETRY, 3: acknowledge writes retried before giving up; legal range 0..7.

Ports:
- clk  in  1  single clock for everything.
- reset_n  in  1  asynchronous, active-low reset.
- irq  in  1  level interrupt from the peripheral, same clock domain.
- enable  in  1  permits starting a new service sequence.
- err_clr  in  1  one-cycle pulse; clears timeout_err and leaves HALT.
- m_cs_n  out  1  active-low chip select to the peripheral.
- m_read  out  1  read strobe.
- m_readdata  in  32  read data from the peripheral.
- m_write  out  1  write strobe.
- m_writedata  out  32  write data.
- busy  out  1  high in every state except IDLE and HALT.
- event_count  out  16  count of successfully serviced interrupts; wraps.
- last_data  out  32  last status word captured.
- timeout_err  out  1  sticky; set when retries are exhausted.

## Operation

- Reset values: m_cs_n=1, m_read=0, m_write=0, m_writedata=0, busy=0, event_count=0, last_data=0, timeout_err=0, state=IDLE, internal counters=0.
- All outputs are registered. Asserting reset_n low at any point, including mid-sequence, forces the reset values immediately.
- States:
  - IDLE: if enable&irq, go to READ.
  - READ: one cycle; m_cs_n=0, m_read=1. Go to RWAIT.
  - RWAIT: lasts READ_LATENCY cycles. On its last cycle, last_data<=m_readdata. Go to WRITE.
  - WRITE: one cycle; m_cs_n=0, m_write=1, m_writedata=ACK_DATA. Clear the wait counter. Go to CLRWAIT.
  - CLRWAIT: if irq==0, event_count<=event_count+1 (mod 2^16), clear the retry counter, and go to IDLE. Otherwise the wait counter increments. When it reaches CLR_TIMEOUT with irq still high:
    - if retry<MAX_RETRY: retry++, go to WRITE;
    - else: timeout_err<=1, clear the retry counter, go to HALT.
  - HALT: strobes inactive. An err_clr pulse clears timeout_err and moves to IDLE. A pending irq is then serviced again if enabled.
- m_cs_n is low only in READ and WRITE. m_read and m_write are never both high.
- Deasserting enable mid-sequence does not abort; the current sequence completes.
- err_clr outside HALT clears timeout_err only, with no state change. If err_clr coincides with timeout_err being set, the set wins.
- event_count wraps from 16'hFFFF to 0 without flagging.

## Timing

Cycle-level sequence for READ_LATENCY=1, with the peripheral dropping irq on the edge ending the write cycle:
- c0: IDLE, irq=1, enable=1.
- c1: READ strobe.
- c2: RWAIT; last_data captured at the end of c2.
- c3: WRITE strobe.
- c4: CLRWAIT sees irq=0; event_count increments at the end of c4.
- c5: IDLE.
- busy is high c1–c4. Minimum service latency from irq seen to write strobe is 3+READ_LATENCY−1 cycles.
- General sequence length: 1 (READ) + READ_LATENCY + 1 (WRITE) + N (CLRWAIT) cycles.
- irq still high in IDLE immediately after a success starts a new sequence the next cycle (back-to-back service).
- Timeout path: CLRWAIT lasts CLR_TIMEOUT cycles per attempt. The total number of write strobes is 1+MAX_RETRY before HALT.

## Test plan

- Basic service, defaults: pulse irq high until the write strobe; peripheral returns 32'hDEADBEEF. Expect one read strobe at c1, last_data=32'hDEADBEEF, one write with m_writedata=0 at c3, event_count=1 at c5, busy high c1–c4.
- READ_LATENCY=3: readdata valid only in the third cycle after the strobe. Expect that value captured and the write strobe at c5.
- Stuck irq, CLR_TIMEOUT=4, MAX_RETRY=2: irq held high. Expect exactly 3 write strobes spaced 5 cycles apart, then HALT with timeout_err=1 and event_count unchanged. An err_clr pulse gives timeout_err=0, then a new READ on the following cycle.
- Drop on retry: irq clears only after the second write. Expect 2 write strobes, event_count+1, timeout_err=0.
- Wrap and enable: preload to 65535 via 65535 serviced events (or force), then service one more. Expect event_count=0. With enable=0 and irq=1, no strobes for 20 cycles. Deasserting enable during RWAIT still completes the write.
- Reset mid-sequence: assert reset_n low during WRITE. Expect m_cs_n=1, m_write=0, all outputs at reset values asynchronously. After release with irq=1, a fresh sequence starts from READ.
